pipe_mem: RTL

- Memory-access stage of the 5-stage pipelined CPU.
- Consumes the EX stage outputs (EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi) through an internal EX/MEM register.
- Performs the data-memory access, then drives the write-back stage through an internal MEM/WB register.
- Also exposes EX/MEM-level forwarding information to the hazard/forwarding unit feeding EX.

---
 rtl/pipe_mem.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_mem.sv
// pipe_mem: memory-access stage with EX/MEM and MEM/WB registers.
// Optional alignment checker enabled by defining PIPE_MEM_ALIGN_CHECK_EN.
module pipe_mem #(
   parameter int ADDR_W = 6
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        EXwreg,
   input  logic        EXm2reg,
   input  logic        EXwmem,
   input  logic [4:0]  EXwn,
   input  logic [31:0] EXaluResult,
   input  logic [31:0] EXdi,
   output logic        MEMwreg,
   output logic        MEMm2reg,
   output logic [4:0]  MEMwn,
   output logic [31:0] MEMaluResult,
   output logic [31:0] MEMmo,
`ifdef PIPE_MEM_ALIGN_CHECK_EN
   output logic        misalign,
   output logic [31:0] bad_addr,
`endif
   output logic        FWDwreg,
   output logic [4:0]  FWDwn,
   output logic [31:0] FWDdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   // EX/MEM fields
   logic        em_wreg;
   logic        em_m2reg;
   logic        em_wmem;
   logic [4:0]  em_wn;
   logic [31:0] em_alu;
   logic [31:0] em_di;

   // data RAM and access signals
   logic [31:0]       ram [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic [31:0]       rd_data;
   logic              wr_en;
   logic              wb_wreg;

   // EX/MEM pipeline register, cleared asynchronously
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         em_wreg  <= 1'b0;
         em_m2reg <= 1'b0;
         em_wmem  <= 1'b0;
         em_wn    <= '0;
         em_alu   <= '0;
         em_di    <= '0;
      end else begin
         em_wreg  <= EXwreg;
         em_m2reg <= EXm2reg;
         em_wmem  <= EXwmem;
         em_wn    <= EXwn;
         em_alu   <= EXaluResult;
         em_di    <= EXdi;
      end
   end

   assign FWDwreg = em_wreg;
   assign FWDwn   = em_wn;
   assign FWDdata = em_alu;

   // low two bits select a byte and the high bits wrap, so only the word index matters
   assign idx     = em_alu[ADDR_W+1:2];
   assign rd_data = ram[idx];

`ifdef PIPE_MEM_ALIGN_CHECK_EN
   logic bad;

   assign bad     = (em_wmem | em_m2reg) & (em_alu[1:0] != 2'b00);
   assign wr_en   = em_wmem & ~bad & ~clrn;
   assign wb_wreg = em_wreg & ~bad;

   // first misaligned access is latched and held until reset
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         misalign <= 1'b0;
         bad_addr <= '0;
      end else if (bad && !misalign) begin
         misalign <= 1'b1;
         bad_addr <= em_alu;
      end
   end
`else
   assign wr_en   = em_wmem & ~clrn;
   assign wb_wreg = em_wreg;
`endif

   // synchronous RAM write; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[idx] <= em_di;
      end
   end

   // MEM/WB pipeline register; read data is sampled before this edge's write lands
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         MEMwreg      <= 1'b0;
         MEMm2reg     <= 1'b0;
         MEMwn        <= '0;
         MEMaluResult <= '0;
         MEMmo        <= '0;
      end else begin
         MEMwreg      <= wb_wreg;
         MEMm2reg     <= em_m2reg;
         MEMwn        <= em_wn;
         MEMaluResult <= em_alu;
         MEMmo        <= rd_data;
      end
   end

endmodule
